// File: rtl/uart_top_if.sv
// uart_top_if: control and status bundle of the loopback UART.
// The top module takes the slave side; the owner of the block takes the master side.
interface uart_top_if;
    logic       tx_en;
    logic       rx_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       tx_start;
    logic       rx_start;
    logic       tx_busy;
    logic       rx_busy;
    logic       tx_done;
    logic       rx_done;

    modport master (
        output tx_en, rx_en, data_in,
        input  data_out, tx_start, rx_start,
        input  tx_busy, rx_busy, tx_done, rx_done
    );

    modport slave (
        input  tx_en, rx_en, data_in,
        output data_out, tx_start, rx_start,
        output tx_busy, rx_busy, tx_done, rx_done
    );
endinterface

// File: rtl/uart_top.sv
// uart_top: 8N1 UART transmitter and receiver joined by an internal
// loopback line; used as a self-test block.
module uart_top #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input logic       clk,
    input logic       reset,
    uart_top_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shreg;
    logic          armed;
    logic          tx_line;
    logic          tx_bit_end;
    logic          tx_go;

    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shreg;
    logic          rx_err;
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_fall, rx_bit_end, rx_half;
    logic          rx_start_q, rx_busy_q, rx_done_q;
    logic [7:0]    data_q;

    // armed keeps tx_start low while reset is held and until the first edge after it.
    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_go      = armed && bus.tx_en && (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        unique case (tx_state)
            TX_IDLE:  if (tx_go) tx_next = TX_START;
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shreg[0];
                if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP:  if (tx_bit_end) tx_next = TX_DONE;
            TX_DONE:  tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
        end else begin
            armed <= 1'b1;
            if (tx_go) begin
                tx_shreg <= bus.data_in;
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end else if (tx_state inside {TX_START, TX_DATA, TX_STOP}) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shreg <= tx_shreg >> 1;
                        tx_idx   <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.tx_start = tx_go;
    assign bus.tx_busy  = tx_state inside {TX_START, TX_DATA, TX_STOP};
    assign bus.tx_done  = (tx_state == TX_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= tx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall    = rx_prev && !rx_s2;
    assign rx_bit_end = (rx_cnt == BIT_LAST);
    assign rx_half    = (rx_cnt == HALF_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // A framing error parks in STOP until the line is high again.
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (bus.rx_en && rx_fall) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if ((rx_bit_end || rx_err) && rx_s2) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shreg   <= '0;
            rx_err     <= 1'b0;
            rx_start_q <= 1'b0;
            rx_busy_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            rx_start_q <= 1'b0;
            rx_done_q  <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    rx_err <= 1'b0;
                    if (rx_next == RX_START) begin
                        rx_start_q <= 1'b1;
                        rx_busy_q  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        rx_cnt <= '0;
                        if (rx_s2) rx_busy_q <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    rx_cnt <= rx_bit_end ? '0 : rx_cnt + CW'(1);
                    if (rx_bit_end && !rx_s2) rx_err <= 1'b1;
                    if (rx_next == RX_IDLE) begin
                        rx_busy_q <= 1'b0;
                        if (!rx_err) begin
                            data_q    <= rx_shreg;
                            rx_done_q <= 1'b1;
                        end
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    assign bus.rx_start = rx_start_q;
    assign bus.rx_busy  = rx_busy_q;
    assign bus.rx_done  = rx_done_q;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized loopback bench; a monitor pops expected frames
// from scoreboard queues and checks data, pulse widths and frame timing.
module tb_uart_top;
    localparam int CPB   = 20;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] b;
        bit         rx;
        int         t0;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_txs = 0, n_txd = 0, n_rxs = 0, n_rxd = 0;

    frame_t     tx_q[$];
    frame_t     rx_q[$];
    logic [7:0] exp_dout = 8'h00;
    bit         busy_bad = 1'b0;
    bit         prev_txd = 1'b0;
    bit         prev_rxd = 1'b0;

    uart_top_if bus();

    uart_top #(
        .CLK_FREQ (100000000),
        .BAUD_RATE(100000000 / CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [13:0] outs();
        return {bus.data_out, bus.tx_start, bus.rx_start,
                bus.tx_busy, bus.rx_busy, bus.tx_done, bus.rx_done};
    endfunction

    // Monitor: samples 2 units after each falling edge; inputs move at +1.
    always begin : monitor
        frame_t f;
        @(negedge clk);
        #2;
        if (!reset) begin
            tx_q.delete();
            rx_q.delete();
            exp_dout = 8'h00;
            busy_bad = 1'b0;
            prev_txd = 1'b0;
            prev_rxd = 1'b0;
        end else begin
            if (bus.tx_start) begin
                n_txs++;
                f.b  = bus.data_in;
                f.rx = bus.rx_en;
                f.t0 = cyc;
                tx_q.push_back(f);
                if (f.rx) rx_q.push_back(f);
                check("tx_busy_at_start", bus.tx_busy, 0);
            end else if (tx_q.size() > 0 && !bus.tx_done && !bus.tx_busy) begin
                busy_bad = 1'b1;
            end
            if (bus.rx_start) begin
                n_rxs++;
                check("rx_start_expected", rx_q.size() > 0, 1);
                check("rx_busy_at_start", bus.rx_busy, 1);
            end
            if (bus.rx_done) begin
                n_rxd++;
                check("rx_done_width", prev_rxd, 0);
                check("rx_busy_at_done", bus.rx_busy, 0);
                check("rx_done_expected", rx_q.size() > 0, 1);
                if (rx_q.size() > 0) begin
                    f = rx_q.pop_front();
                    check("rx_data", bus.data_out, f.b);
                    check("rx_before_tx_done",
                          (cyc - f.t0 > 9 * CPB) && (cyc - f.t0 < FRAME + 1), 1);
                    exp_dout = f.b;
                end
            end
            if (bus.tx_done) begin
                n_txd++;
                check("tx_done_width", prev_txd, 0);
                check("tx_busy_at_done", bus.tx_busy, 0);
                check("tx_done_expected", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) begin
                    f = tx_q.pop_front();
                    check("tx_done_latency", cyc - f.t0, FRAME + 1);
                    check("tx_busy_span", busy_bad, 0);
                    check("rx_pending_at_tx_done", rx_q.size(), 0);
                    check("data_out_hold", bus.data_out, exp_dout);
                end
                busy_bad = 1'b0;
            end
            prev_txd = bus.tx_done;
            prev_rxd = bus.rx_done;
        end
    end

    task automatic drive_point();
        @(negedge clk);
        #1;
    endtask

    // Returns at the drive point of the tx_done cycle.
    task automatic wait_tx_done();
        bit seen = 1'b0;
        for (int n = 0; n < FRAME + 4 * CPB; n++) begin
            drive_point();
            if (bus.tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("tx_done_seen", seen, 1);
    endtask

    logic [7:0] fixed [3];
    logic [7:0] b;
    int s_txs, s_txd, s_rxs, s_rxd;

    initial begin
        fixed[0] = 8'h55;
        fixed[1] = 8'hF0;
        fixed[2] = 8'h0F;
        bus.tx_en   = 1'b1;
        bus.rx_en   = 1'b1;
        bus.data_in = 8'hAA;

        repeat (2) begin
            @(negedge clk);
            #2;
            check("reset_outputs", outs(), 0);
        end
        drive_point();
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("tx_start_after_reset", bus.tx_start, 1);

        for (int i = 0; i < 13; i++) begin
            wait_tx_done();
            drive_point();
            bus.data_in = (i < 3) ? fixed[i] : 8'($urandom);
            if (i >= 3) begin
                repeat ($urandom_range(5, 120)) drive_point();
                bus.data_in = 8'($urandom);
                bus.tx_en   = 1'b0;
                bus.rx_en   = 1'($urandom);
                repeat ($urandom_range(1, 30)) drive_point();
                bus.tx_en = 1'b1;
                bus.rx_en = 1'b1;
            end
        end
        wait_tx_done();
        bus.tx_en = 1'b0;
        @(negedge clk);
        #3;
        check("data_out_after_stream", bus.data_out, exp_dout);

        reset = 1'b0;
        repeat (2) drive_point();
        check("reset2_outputs", outs(), 0);
        reset = 1'b1;
        s_txs = n_txs; s_rxs = n_rxs; s_rxd = n_rxd;
        repeat (20000) drive_point();
        check("idle_no_tx_start", n_txs - s_txs, 0);
        check("idle_no_rx_start", n_rxs - s_rxs, 0);
        check("idle_no_rx_done", n_rxd - s_rxd, 0);
        check("idle_data_out", bus.data_out, 8'h00);

        s_txd = n_txd; s_rxs = n_rxs; s_rxd = n_rxd;
        bus.rx_en   = 1'b0;
        bus.data_in = 8'h3C;
        bus.tx_en   = 1'b1;
        wait_tx_done();
        bus.tx_en = 1'b0;
        @(negedge clk);
        #3;
        check("rx_off_tx_done", n_txd - s_txd, 1);
        check("rx_off_no_rx_start", n_rxs - s_rxs, 0);
        check("rx_off_no_rx_done", n_rxd - s_rxd, 0);
        check("rx_off_data_out", bus.data_out, 8'h00);
        bus.rx_en = 1'b1;

        repeat (4) drive_point();
        s_txd = n_txd; s_rxd = n_rxd;
        bus.data_in = 8'hAA;
        bus.tx_en   = 1'b1;
        repeat (3 * CPB + 5) drive_point();
        reset = 1'b0;
        #1;
        check("reset_mid_data", outs(), 0);
        repeat (2) drive_point();
        check("reset_mid_no_done", (n_txd - s_txd) + (n_rxd - s_rxd), 0);
        b = 8'($urandom);
        bus.data_in = b;
        reset = 1'b1;
        wait_tx_done();
        bus.tx_en = 1'b0;
        @(negedge clk);
        #3;
        check("post_reset_tx_done", n_txd - s_txd, 1);
        check("post_reset_rx_done", n_rxd - s_rxd, 1);
        check("post_reset_data", bus.data_out, b);
        repeat (5) drive_point();
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_top.md
Name: uart_top

Overview:
- Self-contained 8N1 UART transceiver with an internal loopback.
- The transmitter serialises data_in onto an internal serial line. The receiver deserialises that same line and presents the byte on data_out.
- Used as a bring-up and self-test block: every byte transmitted must be received back intact.
- No external serial pins. All status is exported as handshake and status flags.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 868 at defaults), clock cycles per serial bit. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- tx_en  input  1  transmit enable; while high, the transmitter auto-starts a frame whenever it is idle.
- rx_en  input  1  receive enable; while low, the receiver ignores the line.
- data_in  input  8  byte to transmit; sampled on the tx_start cycle.
- data_out  output  8  last correctly received byte.
- tx_start  output  1  one-cycle pulse when a frame transmission begins.
- rx_start  output  1  one-cycle pulse when the receiver detects a start-bit falling edge.
- tx_busy  output  1  high from the cycle after tx_start until tx_done.
- rx_busy  output  1  high while the receiver is inside a frame.
- tx_done  output  1  one-cycle pulse after the stop bit has been fully driven.
- rx_done  output  1  one-cycle pulse when a valid byte is written to data_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0; data_out=8'h00.
  - Internal serial line is 1 (idle).
  - Both FSMs go to IDLE and all counters clear.
- Frame format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles. Frame = 10*CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: the line is 1. If tx_en=1, pulse tx_start, latch data_in into the shift register, and go to START. The line drives 0 from the next cycle.
  - START, DATA, STOP: drive the respective bit for CLKS_PER_BIT cycles each. DATA uses a 3-bit index 0..7 and leaves after bit 7.
  - DONE: one cycle with tx_done=1 and tx_busy=0, then IDLE.
  - The earliest next tx_start is the cycle after DONE, so back-to-back frames are separated by 2 idle-line cycles.
  - With defaults, tx_done is 1+8680 cycles after tx_start.
  - tx_en dropping mid-frame does not abort the frame. It only suppresses the next start.
  - Changes on data_in after tx_start do not affect the frame in flight.
- RX path:
  - The line passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE with rx_en=1: a 1->0 transition on the synchronized line pulses rx_start, sets rx_busy, and enters START.
  - START: sample at CLKS_PER_BIT/2.
    - If the sample is 1, it is a false start: return to IDLE and clear rx_busy. No rx_done.
    - If the sample is 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles at bit centres, shifting LSB first. Leave after 8 bits.
  - STOP: sample at the centre of the stop bit.
    - If 1: data_out takes the byte, rx_done pulses for one cycle, rx_busy clears, return to IDLE.
    - If 0 (framing error): discard the byte. data_out and rx_done are unchanged. Return to IDLE once the line is high.
  - In loopback, rx_done always precedes the matching tx_done, by about half a bit period.
  - rx_en low in IDLE blocks frame detection. Dropping rx_en mid-frame does not abort the frame.
- data_out holds its value between rx_done pulses.
- Reset asserted mid-frame aborts both FSMs immediately and returns every output to its reset value. No done pulses occur.

Test Plan:
- Reset low for 2 cycles with tx_en=rx_en=1 -> all outputs 0 during reset. tx_start pulses 1 cycle after release.
- data_in=8'hAA -> one tx_start, then rx_start, then rx_done with data_out=8'hAA, then tx_done 8681 cycles after tx_start. tx_busy is high throughout.
- Change data_in after each negedge of tx_done to 8'h55, 8'hF0, 8'h0F -> data_out matches each byte in turn. Each tx_done and rx_done is exactly 1 cycle wide.
- tx_en=0 from reset -> no tx_start, rx_start, or rx_done for 20000 cycles. data_out stays 8'h00.
- rx_en=0 while transmitting 8'h3C -> tx_done occurs, no rx_start or rx_done, data_out unchanged.
- Assert reset mid-DATA of 8'hAA -> outputs return to 0 immediately with no tx_done or rx_done. After release, the next frame transmits and receives correctly.
